switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, the number of switch bits handled.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the consecutive stable cycles needed to accept a change; legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port switch_raw, input, WIDTH bits, the raw, asynchronous, bouncing board switches.
REQ-006 The block SHALL have port switch, output, WIDTH bits, the debounced switch levels, which drive the downstream switch-to-LED logic.
REQ-007 The block SHALL have port rise, output, WIDTH bits, a per-bit one-cycle pulse when the switch bit goes 0->1.
REQ-008 The block SHALL have port fall, output, WIDTH bits, a per-bit one-cycle pulse when the switch bit goes 1->0.
REQ-009 The block SHALL have port changed, output, 1 bit, a one-cycle pulse when any switch bit updates.

Function
REQ-010 Each switch_raw bit SHALL pass through a two-flop synchronizer (sync1 -> sync2) before any other logic.
REQ-011 Each bit SHALL have an independent counter; counter width is clog2(DEBOUNCE_CYCLES)+1 bits and SHALL never wrap.
REQ-012 On each edge where sync2[i] == switch[i], counter[i] SHALL clear to 0.
REQ-013 On each edge where sync2[i] != switch[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-014 On the edge where sync2[i] != switch[i] and counter[i] == DEBOUNCE_CYCLES-1, switch[i] SHALL take sync2[i] and counter[i] SHALL clear.
REQ-015 Latency: for a clean raw change sampled at edge 1, switch SHALL update at edge DEBOUNCE_CYCLES+2, and not earlier.
REQ-016 A raw pulse or glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL leave switch unchanged and SHALL restart the count.
REQ-017 rise[i] / fall[i] SHALL be high for exactly the one cycle after the edge where switch[i] updates, and are registered alongside switch.
REQ-018 changed SHALL be the registered OR of all bit updates on that edge.
REQ-019 Bits SHALL be fully independent; simultaneous changes on several bits SHALL update in the same cycle, with a single changed pulse.
REQ-020 rise[i] and fall[i] SHALL never be high in the same cycle.
REQ-021 Back-to-back accepted changes on one bit SHALL be at least DEBOUNCE_CYCLES cycles apart.

Reset
REQ-022 While rst_n is low, sync1, sync2, switch, rise, fall, changed and all counters SHALL be 0, regardless of clk.
REQ-023 Reset asserted mid-count SHALL discard the partial count; after release a full DEBOUNCE_CYCLES+2 latency SHALL apply.
REQ-024 If switch_raw[i] is 1 when reset releases, switch[i] SHALL rise after DEBOUNCE_CYCLES+2 edges, with a rise[i] pulse.
REQ-025 Assertion of reset SHALL never produce a fall pulse.

Configuration
REQ-026 With macro SWITCH_DEBOUNCE_EDGE_EN defined, rise, fall and changed SHALL behave per REQ-017..REQ-020.
REQ-027 Without SWITCH_DEBOUNCE_EDGE_EN, rise, fall and changed SHALL be constant 0, and their registers SHALL not be built.
REQ-028 The behaviour of switch SHALL be identical in both configurations.

Verification (DEBOUNCE_CYCLES=4, WIDTH=6, edge macro defined)
REQ-029 Clean step: reset, then switch_raw 6'h00 -> 6'h01 held -> switch=6'h01 exactly 6 edges later; rise=6'h01 and changed=1 for one cycle.
REQ-030 Glitch: switch_raw bit 2 high for 3 cycles then low -> switch stays 6'h00, with no rise, fall or changed pulse.
REQ-031 Bounce: bit 0 toggling 1,0,1,0 per cycle, then held 1 -> switch[0]=1 exactly 6 edges after the final 0->1.
REQ-032 Multi-bit: switch_raw 6'h00 -> 6'h3F in one cycle -> switch=6'h3F in one cycle, rise=6'h3F, a single changed pulse; release to 6'h00 gives fall=6'h3F.
REQ-033 Reset mid-count: raw 6'h10, rst_n low at edge 3 for 2 cycles then high -> switch=6'h00 during reset; switch=6'h10 at edge 6 after release, with rise=6'h10.
REQ-034 Rebuild without SWITCH_DEBOUNCE_EDGE_EN and rerun REQ-029 -> switch timing identical; rise, fall and changed constantly 0.

Source files
------------

// File: rtl/switch_debounce.sv
// switch_debounce: per-bit debouncer for raw board switches.
// Each raw bit is synchronized through two flops, then accepted only after it
// has differed from the debounced level for DEBOUNCE_CYCLES consecutive edges.
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN builds the registered
// rise/fall/changed pulse outputs; without it those outputs are tied to 0.
module switch_debounce #(
   parameter int WIDTH           = 6,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] switch_raw,
   output logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   // One extra bit over clog2 so the terminal value always fits without wrap.
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_switch;
   logic [WIDTH-1:0] w_update;

   // Two-flop synchronizer for the asynchronous switch inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= switch_raw;
         r_sync2 <= r_sync1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [CW-1:0] r_count;

         // A bit is accepted on the edge its run of disagreement reaches the limit.
         assign w_update[gi] = (r_sync2[gi] != r_switch[gi]) && (r_count == LAST);

         // Count consecutive cycles of disagreement; any agreement restarts it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_count <= '0;
            end else if (r_sync2[gi] == r_switch[gi]) begin
               r_count <= '0;
            end else if (r_count == LAST) begin
               r_count <= '0;
            end else begin
               r_count <= r_count + CW'(1);
            end
         end
      end
   endgenerate

   // Debounced level: take the synchronized value only on accepted bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_switch <= '0;
      end else begin
         r_switch <= (r_switch & ~w_update) | (r_sync2 & w_update);
      end
   end

   assign switch = r_switch;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic             r_changed;

   // Edge pulses registered on the same edge that updates the level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rise    <= '0;
         r_fall    <= '0;
         r_changed <= 1'b0;
      end else begin
         r_rise    <= w_update & r_sync2;
         r_fall    <= w_update & ~r_sync2;
         r_changed <= |w_update;
      end
   end

   assign rise    = r_rise;
   assign fall    = r_fall;
   assign changed = r_changed;
`else
   assign rise    = '0;
   assign fall    = '0;
   assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed stimulus with a window-based reference model.
// The model says a bit flips on the edge where the last DEBOUNCE_CYCLES
// synchronized samples (raw delayed by two edges) all disagree with it.
module tb_switch_debounce;

   localparam int W = 6;
   localparam int D = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic [W-1:0] switch_raw;
   logic [W-1:0] switch;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         changed;

   int checks = 0;
   int errors = 0;

   switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .switch_raw (switch_raw),
      .switch     (switch),
      .rise       (rise),
      .fall       (fall),
      .changed    (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] raw_q[$];
   logic [W-1:0] m_sw, m_rise, m_fall, m_upd;
   logic         m_ch;
   int           n, idx;
   logic         v, all_diff;

   task automatic model_clear();
      raw_q.delete();
      m_sw = '0; m_rise = '0; m_fall = '0; m_ch = 1'b0;
   endtask

   always @(negedge rst_n) model_clear();

   always @(posedge clk) begin
      if (!rst_n) begin
         model_clear();
      end else begin
         raw_q.push_back(switch_raw);
         n = raw_q.size();
         m_upd = '0;
         for (int i = 0; i < W; i++) begin
            all_diff = (n >= D);
            for (int j = n - D + 1; j <= n; j++) begin
               idx = j - 2;
               v = (idx >= 1) ? raw_q[idx-1][i] : 1'b0;
               if (v == m_sw[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
               m_upd[i] = 1'b1;
               m_sw[i]  = ~m_sw[i];
            end
         end
         m_rise = EDGE_EN ? (m_upd & m_sw)  : '0;
         m_fall = EDGE_EN ? (m_upd & ~m_sw) : '0;
         m_ch   = EDGE_EN ? (|m_upd)        : 1'b0;
      end
      #1;
      chk("model_switch",  32'(switch),  32'(m_sw));
      chk("model_rise",    32'(rise),    32'(m_rise));
      chk("model_fall",    32'(fall),    32'(m_fall));
      chk("model_changed", 32'(changed), 32'(m_ch));
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset(input logic [W-1:0] raw);
      @(negedge clk);
      rst_n = 1'b0;
      switch_raw = raw;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   typedef struct { logic [W-1:0] raw; int hold; } vec_t;
   vec_t tbl[12];
   logic [W-1:0] bounce_seq[5];
   logic [W-1:0] pulse_acc;

   initial begin
      rst_n = 1'b0;
      switch_raw = '0;
      #1;
      chk("reset_switch",  32'(switch),  32'h0);
      chk("reset_rise",    32'(rise),    32'h0);
      chk("reset_changed", 32'(changed), 32'h0);

      // clean step: edge 1 samples 01, switch updates at edge 6
      do_reset('0);
      repeat (2) @(negedge clk);
      switch_raw = 6'h01;
      wait_edges(5);
      chk("step_not_early", 32'(switch), 32'h00);
      wait_edges(1);
      chk("step_switch",  32'(switch),  32'h01);
      chk("step_rise",    32'(rise),    EDGE_EN ? 32'h01 : 32'h0);
      chk("step_changed", 32'(changed), EDGE_EN ? 32'h1 : 32'h0);
      chk("step_fall",    32'(fall),    32'h0);
      wait_edges(1);
      chk("step_rise_once",    32'(rise),    32'h0);
      chk("step_changed_once", 32'(changed), 32'h0);
      $display("step: switch=%0h", switch);

      // glitch: bit 2 high for 3 cycles
      do_reset('0);
      @(negedge clk);
      switch_raw = 6'h04;
      repeat (3) @(negedge clk);
      switch_raw = 6'h00;
      pulse_acc = '0;
      for (int k = 0; k < 12; k++) begin
         wait_edges(1);
         pulse_acc |= rise | fall | {W{changed}};
      end
      chk("glitch_switch", 32'(switch),    32'h00);
      chk("glitch_pulses", 32'(pulse_acc), 32'h00);
      $display("glitch: switch=%0h", switch);

      // bounce: 1,0,1,0 then held 1
      do_reset('0);
      bounce_seq = '{6'h01, 6'h00, 6'h01, 6'h00, 6'h01};
      foreach (bounce_seq[k]) begin
         @(negedge clk);
         switch_raw = bounce_seq[k];
      end
      wait_edges(5);
      chk("bounce_not_early", 32'(switch[0]), 32'h0);
      wait_edges(1);
      chk("bounce_switch", 32'(switch[0]), 32'h1);
      chk("bounce_rise",   32'(rise),      EDGE_EN ? 32'h01 : 32'h0);
      $display("bounce: switch=%0h", switch);

      // multi-bit press then release
      do_reset('0);
      @(negedge clk);
      switch_raw = 6'h3F;
      wait_edges(5);
      chk("multi_not_early", 32'(switch), 32'h00);
      wait_edges(1);
      chk("multi_switch",  32'(switch),  32'h3F);
      chk("multi_rise",    32'(rise),    EDGE_EN ? 32'h3F : 32'h0);
      chk("multi_changed", 32'(changed), EDGE_EN ? 32'h1 : 32'h0);
      wait_edges(1);
      chk("multi_changed_single", 32'(changed), 32'h0);
      @(negedge clk);
      switch_raw = 6'h00;
      wait_edges(6);
      chk("multi_release_switch", 32'(switch), 32'h00);
      chk("multi_release_fall",   32'(fall),   EDGE_EN ? 32'h3F : 32'h0);
      chk("multi_release_rise",   32'(rise),   32'h0);
      $display("multi: switch=%0h", switch);

      // reset mid-count
      do_reset('0);
      @(negedge clk);
      switch_raw = 6'h10;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_switch", 32'(switch), 32'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_edges(5);
      chk("midreset_not_early", 32'(switch), 32'h00);
      wait_edges(1);
      chk("midreset_switch_after", 32'(switch), 32'h10);
      chk("midreset_rise",         32'(rise),   EDGE_EN ? 32'h10 : 32'h0);
      $display("midreset: switch=%0h", switch);

      // asynchronous reset assertion with switches high: no fall pulse
      do_reset('0);
      @(negedge clk);
      switch_raw = 6'h3F;
      wait_edges(8);
      chk("async_pre_switch", 32'(switch), 32'h3F);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_switch", 32'(switch), 32'h00);
      chk("async_fall",   32'(fall),   32'h00);
      wait_edges(1);
      chk("async_fall_edge", 32'(fall), 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      $display("async reset: switch=%0h", switch);

      // mixed bouncing table, checked cycle by cycle by the model
      tbl = '{'{6'h01, 2}, '{6'h00, 1}, '{6'h03, 5}, '{6'h07, 3},
              '{6'h03, 6}, '{6'h23, 4}, '{6'h20, 7}, '{6'h00, 2},
              '{6'h3C, 9}, '{6'h3C, 3}, '{6'h00, 6}, '{6'h15, 10}};
      foreach (tbl[k]) begin
         @(negedge clk);
         switch_raw = tbl[k].raw;
         repeat (tbl[k].hold - 1) @(negedge clk);
         $display("vec %0d: raw=%0h hold=%0d switch=%0h", k, tbl[k].raw, tbl[k].hold, switch);
      end
      wait_edges(1);
      chk("table_final_switch", 32'(switch), 32'h15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
